// File: rtl/idex_pkg.sv
// Shared definitions for the decode-to-execute skid stage: control bundle
// layout, default widths and the occupancy state encoding.
package idex_pkg;

    localparam int CTRL_W_DEF = 10;

    localparam int CTRL_REGWRITE   = 0;
    localparam int CTRL_MEMWRITE   = 1;
    localparam int CTRL_JUMP       = 2;
    localparam int CTRL_BRANCH     = 3;
    localparam int CTRL_ALUSRC     = 4;
    localparam int CTRL_RESSRC_LSB = 5;
    localparam int CTRL_ALUCTL_LSB = 7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } idex_state_e;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/idex_payload_reg.sv
// Payload register for one stage entry: async reset, synchronous clear,
// load enable. Clear wins over load.
module idex_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/idex_skid_stage.sv
// ID/EX pipeline stage with valid/ready handshake, two-entry skid buffer
// (MAIN drives the outputs, SKID catches the bundle accepted while stalling).
module idex_skid_stage
    import idex_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [NUM_SRC*XLEN-1:0] in_src,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [XLEN-1:0]         in_imm,
    input  logic [XLEN-1:0]         in_pcplus4,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [NUM_SRC*XLEN-1:0] out_src,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_imm,
    output logic [XLEN-1:0]         out_pcplus4,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [1:0]              dbg_state
);

    localparam int PAYLOAD_W = CTRL_W + (NUM_SRC + 3) * XLEN;
    localparam int SRC_LSB   = CTRL_W;
    localparam int PC_LSB    = SRC_LSB + NUM_SRC * XLEN;
    localparam int IMM_LSB   = PC_LSB + XLEN;
    localparam int P4_LSB    = IMM_LSB + XLEN;

    // Handshake: a bundle moves when valid and ready are both high at the
    // rising edge; in_ready depends only on state, never on out_ready.
    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [PAYLOAD_W-1:0] in_payload, main_q, main_d, skid_q;
    logic                 main_load, skid_load, main_from_skid, in_fire;

    assign in_payload = {in_pcplus4, in_imm, in_pc, in_src, in_ctrl};
    assign in_ready   = (state_q != ST_TWO);
    assign out_valid  = (state_q != ST_EMPTY);
    assign in_fire    = in_valid & in_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_load = 1'b1;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_ready) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    skid_load = 1'b1;
                    state_d   = ST_TWO;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_ready) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
        main_d = main_from_skid ? skid_q : in_payload;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    idex_payload_reg #(.W(PAYLOAD_W)) u_main (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    idex_payload_reg #(.W(PAYLOAD_W)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .load (skid_load),
        .d    (in_payload),
        .q    (skid_q)
    );

    // Empty slots present a zero control bundle so no write can leak out.
    assign out_ctrl    = out_valid ? main_q[CTRL_W-1:0] : '0;
    assign out_src     = main_q[SRC_LSB +: NUM_SRC*XLEN];
    assign out_pc      = main_q[PC_LSB +: XLEN];
    assign out_imm     = main_q[IMM_LSB +: XLEN];
    assign out_pcplus4 = main_q[P4_LSB +: XLEN];
    assign stall_cnt   = stall_cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_idex_skid_stage.sv
// Directed bench for idex_skid_stage: vector table plus hand sequences for
// async reset and stall-counter saturation (second instance with CNT_W=4).
module tb_idex_skid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, in_valid, out_ready;
    logic [9:0]  in_ctrl;
    logic [63:0] in_src;
    logic [31:0] in_pc, in_imm, in_pcplus4;

    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [9:0]  out_ctrl, out_ctrl2;
    logic [63:0] out_src, out_src2;
    logic [31:0] out_pc, out_imm, out_pcplus4, out_pc2, out_imm2, out_pcplus42;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt2;
    logic [1:0]  dbg_state, dbg_state2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    idex_skid_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_src(in_src), .in_pc(in_pc), .in_imm(in_imm),
        .in_pcplus4(in_pcplus4), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_src(out_src), .out_pc(out_pc), .out_imm(out_imm),
        .out_pcplus4(out_pcplus4), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    idex_skid_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .in_ctrl(in_ctrl), .in_src(in_src), .in_pc(in_pc), .in_imm(in_imm),
        .in_pcplus4(in_pcplus4), .out_valid(out_valid2), .out_ready(out_ready),
        .out_ctrl(out_ctrl2), .out_src(out_src2), .out_pc(out_pc2), .out_imm(out_imm2),
        .out_pcplus4(out_pcplus42), .stall_cnt(stall_cnt2), .dbg_state(dbg_state2)
    );

    typedef struct {
        logic        iv, ordy, fl;
        logic [9:0]  ctrl;
        logic [31:0] pc;
        logic        e_ov, e_ir, e_clr;
        logic [9:0]  e_ctrl;
        logic [31:0] e_pc;
        int          e_cnt;
        logic [1:0]  e_st;
    } vec_t;

    vec_t vt[16];

    function automatic logic [63:0] src_of(input logic [31:0] pc);
        return {pc ^ 32'h5A5A_0000, pc ^ 32'hA5A5_0000};
    endfunction

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                                input logic [9:0] ctrl, input logic [31:0] pc,
                                input logic e_ov, input logic e_ir, input logic e_clr,
                                input logic [9:0] e_ctrl, input logic [31:0] e_pc,
                                input int e_cnt, input logic [1:0] e_st);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.ctrl = ctrl; v.pc = pc;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_clr = e_clr; v.e_ctrl = e_ctrl;
        v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_st = e_st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [9:0] ctrl, input logic [31:0] pc);
        in_valid   = iv;
        out_ready  = ordy;
        flush      = fl;
        in_ctrl    = ctrl;
        in_pc      = pc;
        in_src     = src_of(pc);
        in_imm     = pc + 32'd100;
        in_pcplus4 = pc + 32'd4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_data(input string tag, input logic clr, input logic [31:0] pc);
        chk({tag, ".pc"}, {32'b0, out_pc}, {32'b0, pc});
        chk({tag, ".src"}, out_src, clr ? 64'b0 : src_of(pc));
        chk({tag, ".imm"}, {32'b0, out_imm}, clr ? 64'b0 : {32'b0, pc + 32'd100});
        chk({tag, ".p4"}, {32'b0, out_pcplus4}, clr ? 64'b0 : {32'b0, pc + 32'd4});
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);

        //      iv ordy fl ctrl    pc  | ov ir clr e_ctrl  e_pc cnt st
        vt[0]  = mk(1, 1, 0, 10'h3FF,  0,  1, 1, 0, 10'h3FF,  0, 0, 2'd1);
        vt[1]  = mk(1, 1, 0, 10'h3FF,  4,  1, 1, 0, 10'h3FF,  4, 0, 2'd1);
        vt[2]  = mk(1, 1, 0, 10'h3FF,  8,  1, 1, 0, 10'h3FF,  8, 0, 2'd1);
        vt[3]  = mk(1, 0, 0, 10'h3FF, 12,  1, 0, 0, 10'h3FF,  8, 1, 2'd2);
        vt[4]  = mk(1, 0, 0, 10'h3FF, 16,  1, 0, 0, 10'h3FF,  8, 2, 2'd2);
        vt[5]  = mk(1, 0, 0, 10'h3FF, 16,  1, 0, 0, 10'h3FF,  8, 3, 2'd2);
        vt[6]  = mk(1, 1, 0, 10'h3FF, 16,  1, 1, 0, 10'h3FF, 12, 3, 2'd1);
        vt[7]  = mk(1, 1, 0, 10'h3FF, 16,  1, 1, 0, 10'h3FF, 16, 3, 2'd1);
        vt[8]  = mk(0, 1, 0, 10'h3FF, 99,  0, 1, 0, 10'h000, 16, 3, 2'd0);
        vt[9]  = mk(0, 0, 0, 10'h3FF, 99,  0, 1, 0, 10'h000, 16, 3, 2'd0);
        vt[10] = mk(1, 0, 0, 10'h003, 20,  1, 1, 0, 10'h003, 20, 3, 2'd1);
        vt[11] = mk(0, 1, 0, 10'h3FF, 99,  0, 1, 0, 10'h000, 20, 3, 2'd0);
        vt[12] = mk(1, 0, 0, 10'h3FF, 24,  1, 1, 0, 10'h3FF, 24, 3, 2'd1);
        vt[13] = mk(1, 0, 0, 10'h3FF, 28,  1, 0, 0, 10'h3FF, 24, 4, 2'd2);
        vt[14] = mk(1, 0, 1, 10'h3FF, 32,  0, 1, 1, 10'h000,  0, 5, 2'd0);
        vt[15] = mk(0, 1, 0, 10'h3FF, 99,  0, 1, 1, 10'h000,  0, 5, 2'd0);

        // Reset state while rst is held.
        step();
        chk("rst.out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst.in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst.out_ctrl", {54'b0, out_ctrl}, 64'd0);
        chk("rst.stall_cnt", {48'b0, stall_cnt}, 64'd0);
        chk_data("rst", 1'b1, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].iv, vt[i].ordy, vt[i].fl, vt[i].ctrl, vt[i].pc);
            step();
            chk($sformatf("v%0d.out_valid", i), {63'b0, out_valid}, {63'b0, vt[i].e_ov});
            chk($sformatf("v%0d.in_ready", i), {63'b0, in_ready}, {63'b0, vt[i].e_ir});
            chk($sformatf("v%0d.out_ctrl", i), {54'b0, out_ctrl}, {54'b0, vt[i].e_ctrl});
            chk($sformatf("v%0d.stall_cnt", i), {48'b0, stall_cnt}, 64'(vt[i].e_cnt));
            chk($sformatf("v%0d.state", i), {62'b0, dbg_state}, {62'b0, vt[i].e_st});
            chk($sformatf("v%0d.sat_cnt", i), {60'b0, stall_cnt2},
                64'((vt[i].e_cnt > 15) ? 15 : vt[i].e_cnt));
            chk_data($sformatf("v%0d", i), vt[i].e_clr, vt[i].e_pc);
        end

        // Async reset while in TWO: outputs clear before any clock edge.
        drive(1'b1, 1'b0, 1'b0, 10'h3FF, 32'd40);
        step();
        drive(1'b1, 1'b0, 1'b0, 10'h3FF, 32'd44);
        step();
        chk("pre_rst.state", {62'b0, dbg_state}, 64'd2);
        chk("pre_rst.stall_cnt", {48'b0, stall_cnt}, 64'd6);
        #2 rst = 1'b1;
        #1;
        chk("arst.out_valid", {63'b0, out_valid}, 64'd0);
        chk("arst.in_ready", {63'b0, in_ready}, 64'd1);
        chk("arst.out_ctrl", {54'b0, out_ctrl}, 64'd0);
        chk("arst.stall_cnt", {48'b0, stall_cnt}, 64'd0);
        chk("arst.sat_cnt", {60'b0, stall_cnt2}, 64'd0);
        chk_data("arst", 1'b1, 32'd0);
        step();
        chk("arst_hold.out_valid", {63'b0, out_valid}, 64'd0);
        rst = 1'b0;

        // Saturation: one bundle held against out_ready=0 for 20 cycles.
        drive(1'b1, 1'b0, 1'b0, 10'h3FF, 32'd100);
        step();
        chk("sat.load_pc", {32'b0, out_pc}, 64'd100);
        drive(1'b0, 1'b0, 1'b0, 10'h3FF, 32'd0);
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 15) chk("sat.at15", {60'b0, stall_cnt2}, 64'd15);
        end
        chk("sat.cnt4", {60'b0, stall_cnt2}, 64'd15);
        chk("sat.cnt16", {48'b0, stall_cnt}, 64'd20);
        chk("sat.out_pc", {32'b0, out_pc}, 64'd100);
        drive(1'b0, 1'b1, 1'b0, 10'h3FF, 32'd0);
        step();
        chk("drain.out_valid", {63'b0, out_valid}, 64'd0);
        chk("drain.cnt16", {48'b0, stall_cnt}, 64'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idex_skid_stage.md
# idex_skid_stage

Parametrised decode-to-execute pipeline stage with a valid/ready handshake and a two-entry skid buffer. It replaces the plain clear-only ID/EX register by adding stall back-pressure, bubble tracking, configurable operand count and width, and a stall-cycle counter. It sits between the decode stage and the execute stage, and carries the control bundle, the source operands, PC, the extended immediate and PC+4.

## Interface
- XLEN, 32: width of each data field (operands, PC, immediate, PC+4).
- NUM_SRC, 2: number of register-operand fields carried.
- CTRL_W, 10: control bundle width. Packing is {ALUControl[2:0], ResultSrc[1:0], ALUSrc, branch, jump, MemWrite, RegWrite}, LSB first.
- CNT_W, 16: width of the stall counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- flush  in  1  synchronous kill of all held entries (execute-stage clear).
- in_valid  in  1  decode presents a valid bundle.
- in_ready  out  1  stage can accept; driven only from state, with no combinational path from out_ready.
- in_ctrl  in  CTRL_W  control bundle.
- in_src  in  NUM_SRC*XLEN  operands; operand k occupies bits [k*XLEN +: XLEN].
- in_pc, in_imm, in_pcplus4  in  XLEN each  PC, extended immediate, PC+4.
- out_valid  out  1  execute sees a valid bundle.
- out_ready  in  1  execute consumes this cycle.
- out_ctrl  out  CTRL_W  control bundle; forced to all-zero whenever out_valid=0.
- out_src, out_pc, out_imm, out_pcplus4  out  same widths as the inputs  payload of the head entry.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- The stage holds two entries, MAIN (the head, which drives the outputs) and SKID. Each entry stores ctrl, src, pc, imm and pcplus4.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States are EMPTY, ONE and TWO. in_ready = (state != TWO). out_valid = (state != EMPTY).
- From EMPTY:
  - in_fire: MAIN <= in, go to ONE.
  - Otherwise stay in EMPTY.
- From ONE:
  - in_fire & out_fire: MAIN <= in, stay in ONE.
  - in_fire & !out_ready: SKID <= in, go to TWO.
  - !in_fire & out_fire: go to EMPTY.
  - Otherwise hold.
- From TWO:
  - out_fire: MAIN <= SKID, go to ONE.
  - Otherwise hold. in_valid is ignored because in_ready=0.
- Entries leave in strict FIFO order. No bundle is duplicated or dropped unless a flush kills it.
- flush has the highest priority:
  - Next state is EMPTY.
  - All MAIN and SKID fields are set to zero.
  - Any in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed by execute.
- Bubbles: out_ctrl=0 whenever out_valid=0, so RegWrite and MemWrite can never assert for an empty slot. Data outputs hold the MAIN contents, which are zero after a reset or flush.
- stall_cnt increments by 1 each cycle that out_valid & !out_ready holds, and saturates at 2^CNT_W-1. It is not cleared by flush; only rst clears it.

## Timing
- Reset (async assert, sync deassert by the system): state=EMPTY, every entry field=0, stall_cnt=0. Outputs during reset: out_valid=0, out_ctrl=0, all data outputs 0, in_ready=1. No transfer is registered while rst=1.
- Latency is 1 cycle: a bundle accepted at edge N is on the outputs with out_valid=1 after edge N.
- Throughput is 1 bundle/cycle when out_ready is held at 1.
- After out_ready falls, in_ready falls one cycle later, once the stage reaches TWO. This is why SKID exists.
- Asserting rst mid-operation drops all entries immediately.

## Structure
- Shared package idex_pkg holds:
  - the CTRL_W default;
  - localparam bit indices CTRL_REGWRITE=0, CTRL_MEMWRITE=1, CTRL_JUMP=2, CTRL_BRANCH=3, CTRL_ALUSRC=4, CTRL_RESSRC_LSB=5, CTRL_ALUCTL_LSB=7;
  - the state enum {EMPTY, ONE, TWO}.
- Payload width is PAYLOAD_W = CTRL_W + (NUM_SRC+3)*XLEN.
- One sub-module, idex_payload_reg: a PAYLOAD_W-wide register with async reset, synchronous clear and load enable. It is instantiated twice, once for MAIN and once for SKID.

## Test plan
- Streaming: in_valid=1 with in_ctrl=10'h3FF and pc=0,4,8,… while out_ready=1 → one output per cycle, one cycle late, in order, with in_ready constantly 1.
- Back-pressure: drop out_ready for 3 cycles during streaming → state goes to TWO, in_ready=0 after 1 cycle, stall_cnt=3, and no PC is lost or repeated after release.
- Flush while in TWO, with in_valid=1 in the same cycle → next cycle out_valid=0, out_ctrl=0, all data 0, and the new bundle is dropped.
- Bubble gating: with the stage EMPTY after consuming in_ctrl=10'h003 → out_ctrl=0, so RegWrite and MemWrite are 0.
- Async reset asserted mid-stream in TWO → outputs clear without waiting for a clock edge; stall_cnt=0.
- Saturation with CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt stops at 15.
